// File: rtl/result_pack_stage_if.sv
// Field-select enums, buffered entry type and the two handshake interfaces
// of result_pack_stage.
//   pack_in_if  : upstream word (valid/ready, field selects, sign/exponent/fraction)
//   pack_out_if : downstream packed IEEE-754 word, class flags, delivery count
// Modports: master drives the bus, slave receives it.
package result_pack_pkg;
    typedef enum logic [1:0] {SIGN_RESULT = 2'd0, SIGN_ZERO = 2'd1, SIGN_ONE = 2'd2} sign_e;
    typedef enum logic [1:0] {EXP_RESULT = 2'd0, EXP_ZEROS = 2'd1, EXP_ONES = 2'd2} exponent_e;
    typedef enum logic [1:0] {MSB_RESULT = 2'd0, MSB_ZERO = 2'd1, MSB_ONE = 2'd2} fraction_msb_e;
    typedef enum logic [0:0] {LSBS_RESULT = 1'b0, LSBS_ZEROS = 1'b1} fraction_lsbs_e;

    typedef struct packed {
        logic [31:0] word;
        logic        zero;
        logic        inf;
        logic        nan;
    } entry_t;
endpackage

interface pack_in_if;
    logic                           in_valid;
    logic                           in_ready;
    result_pack_pkg::sign_e         sign_select;
    result_pack_pkg::exponent_e     exponent_select;
    result_pack_pkg::fraction_msb_e fraction_msb_select;
    result_pack_pkg::fraction_lsbs_e fraction_lsbs_select;
    logic                           result_sign;
    logic [9:0]                     result_exponent;
    logic [31:0]                    result_fraction;

    modport master (output in_valid, sign_select, exponent_select, fraction_msb_select,
                           fraction_lsbs_select, result_sign, result_exponent, result_fraction,
                    input  in_ready);
    modport slave  (input  in_valid, sign_select, exponent_select, fraction_msb_select,
                           fraction_lsbs_select, result_sign, result_exponent, result_fraction,
                    output in_ready);
endinterface

interface pack_out_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_inf;
    logic        out_nan;
    logic [15:0] out_count;

    modport master (output out_valid, out_result, out_zero, out_inf, out_nan, out_count,
                    input  out_ready);
    modport slave  (input  out_valid, out_result, out_zero, out_inf, out_nan, out_count,
                    output out_ready);
endinterface

// File: rtl/result_pack_stage.sv
// Result pack stage: assembles an IEEE-754 single word from the selected
// sign/exponent/fraction sources, classifies it (zero/inf/nan) and buffers
// it in a 2-entry main+skid FIFO so in_ready is a pure register output.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   up (slave)   : upstream word + field selects, in_valid/in_ready
//   dn (master)  : out_valid/out_ready, out_result, out_zero/inf/nan, out_count
module result_pack_stage
    import result_pack_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    pack_in_if.slave    up,
    pack_out_if.master  dn
);
    entry_t      pk;
    entry_t      main_q, skid_q;
    logic [1:0]  occ, occ_nxt;
    logic        in_ready_q;
    logic [15:0] count_q;
    logic        in_xfer, out_xfer;
    logic        s, m;
    logic [7:0]  e;
    logic [21:0] l;

    // Only exponent[7:0] and fraction[29:7] feed the packed word.
    logic unused_bits;
    assign unused_bits = ^{up.result_exponent[9:8], up.result_fraction[31:30],
                           up.result_fraction[6:0]};

    always_comb begin
        s = 1'b0;
        e = 8'h00;
        m = 1'b0;
        l = 22'h0;
        case (up.sign_select)
            SIGN_RESULT: s = up.result_sign;
            SIGN_ONE:    s = 1'b1;
            default:     s = 1'b0;
        endcase
        case (up.exponent_select)
            EXP_RESULT: e = up.result_exponent[7:0];
            EXP_ONES:   e = 8'hFF;
            default:    e = 8'h00;
        endcase
        case (up.fraction_msb_select)
            MSB_RESULT: m = up.result_fraction[29];
            MSB_ONE:    m = 1'b1;
            default:    m = 1'b0;
        endcase
        if (up.fraction_lsbs_select == LSBS_RESULT) l = up.result_fraction[28:7];
        pk.word = {s, e, m, l};
        pk.zero = (e == 8'h00) && ({m, l} == 23'h0);
        pk.inf  = (e == 8'hFF) && ({m, l} == 23'h0);
        pk.nan  = (e == 8'hFF) && ({m, l} != 23'h0);
    end

    assign in_xfer  = up.in_valid & in_ready_q;
    assign out_xfer = (occ != 2'd0) & dn.out_ready;
    assign occ_nxt  = occ + 2'(in_xfer) - 2'(out_xfer);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ        <= 2'd0;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            count_q    <= 16'h0;
        end else begin
            case (occ)
                2'd0: if (in_xfer) main_q <= pk;
                // Simultaneous in/out at one entry replaces the head in place.
                2'd1: if (in_xfer && out_xfer) main_q <= pk;
                      else if (in_xfer)        skid_q <= pk;
                // Full: in_ready is low, so only a drain can happen.
                default: if (out_xfer) main_q <= skid_q;
            endcase
            occ        <= occ_nxt;
            in_ready_q <= (occ_nxt != 2'd2);
            if (out_xfer) count_q <= count_q + 16'd1;
        end
    end

    assign up.in_ready     = in_ready_q;
    assign dn.out_valid    = (occ != 2'd0);
    assign dn.out_result   = main_q.word;
    assign dn.out_zero     = main_q.zero;
    assign dn.out_inf      = main_q.inf;
    assign dn.out_nan      = main_q.nan;
    assign dn.out_count    = count_q;
endmodule

// File: tb/tb_result_pack_stage.sv
module tb_result_pack_stage;
    import result_pack_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pack_in_if  up_if();
    pack_out_if dn_if();

    result_pack_stage dut (.clk(clk), .reset_n(reset_n), .up(up_if), .dn(dn_if));

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: pack the word from the field rules with arithmetic.
    function automatic logic [31:0] ref_pack(sign_e ss, exponent_e es, fraction_msb_e ms,
                                            fraction_lsbs_e ls, logic rs, logic [9:0] re,
                                            logic [31:0] rf);
        longint sv, ev, mv, lv;
        sv = (ss == SIGN_RESULT) ? longint'(rs) : (ss == SIGN_ONE) ? 1 : 0;
        ev = (es == EXP_RESULT) ? longint'(re) % 256 : (es == EXP_ONES) ? 255 : 0;
        mv = (ms == MSB_RESULT) ? (longint'(rf) / (1 << 29)) % 2 : (ms == MSB_ONE) ? 1 : 0;
        lv = (ls == LSBS_RESULT) ? (longint'(rf) / 128) % (1 << 22) : 0;
        return 32'(sv * (64'd1 << 31) + ev * (1 << 23) + mv * (1 << 22) + lv);
    endfunction

    function automatic int f_exp(logic [31:0] w);  return int'((w >> 23) & 32'hFF); endfunction
    function automatic int f_mant(logic [31:0] w); return int'(w & 32'h7F_FFFF); endfunction

    // Behavioural model: a FIFO of at most two words plus a delivery counter.
    logic [31:0] mq[$];
    logic [15:0] m_count;
    logic        m_ready;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_count = 16'h0;
            m_ready = 1'b0;
        end else begin
            logic ix, ox;
            ix = up_if.in_valid && m_ready;
            ox = (mq.size() > 0) && dn_if.out_ready;
            if (ox) begin
                void'(mq.pop_front());
                m_count = m_count + 16'd1;
            end
            if (ix) mq.push_back(ref_pack(up_if.sign_select, up_if.exponent_select,
                                          up_if.fraction_msb_select, up_if.fraction_lsbs_select,
                                          up_if.result_sign, up_if.result_exponent,
                                          up_if.result_fraction));
            m_ready = (mq.size() < 2);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            check("out_valid", 32'(dn_if.out_valid), 32'(mq.size() > 0));
            check("in_ready",  32'(up_if.in_ready),  32'(m_ready));
            check("out_count", 32'(dn_if.out_count), 32'(m_count));
            if (mq.size() > 0) begin
                check("out_result", dn_if.out_result, mq[0]);
                check("out_zero", 32'(dn_if.out_zero), 32'(f_exp(mq[0]) == 0 && f_mant(mq[0]) == 0));
                check("out_inf",  32'(dn_if.out_inf),  32'(f_exp(mq[0]) == 255 && f_mant(mq[0]) == 0));
                check("out_nan",  32'(dn_if.out_nan),  32'(f_exp(mq[0]) == 255 && f_mant(mq[0]) != 0));
            end
        end
    end

    task automatic drive(input logic v, input sign_e ss, input exponent_e es,
                         input fraction_msb_e ms, input fraction_lsbs_e ls,
                         input logic rs, input logic [9:0] re, input logic [31:0] rf);
        up_if.in_valid             = v;
        up_if.sign_select          = ss;
        up_if.exponent_select      = es;
        up_if.fraction_msb_select  = ms;
        up_if.fraction_lsbs_select = ls;
        up_if.result_sign          = rs;
        up_if.result_exponent      = re;
        up_if.result_fraction      = rf;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, sign_e'($urandom_range(0, 2)), exponent_e'($urandom_range(0, 2)),
              fraction_msb_e'($urandom_range(0, 2)), fraction_lsbs_e'($urandom_range(0, 1)),
              1'($urandom), 10'($urandom), $urandom);
    endtask

    initial begin
        logic [15:0] cnt0;
        int          guard;
        drive(1'b0, SIGN_RESULT, EXP_RESULT, MSB_RESULT, LSBS_RESULT, 1'b0, 10'd0, 32'h0);
        dn_if.out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(dn_if.out_valid), 32'h0);
        check("rst_in_ready",  32'(up_if.in_ready),  32'h0);
        check("rst_out_result", dn_if.out_result,    32'h0);
        check("rst_out_count", 32'(dn_if.out_count), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(up_if.in_ready), 32'h1);

        // All-RESULT: 1.0
        drive(1'b1, SIGN_RESULT, EXP_RESULT, MSB_RESULT, LSBS_RESULT, 1'b0, 10'd127, 32'h4000_0000);
        @(negedge clk);
        check("one_valid",  32'(dn_if.out_valid), 32'h1);
        check("one_result", dn_if.out_result, 32'h3F80_0000);
        check("one_flags",  32'({dn_if.out_zero, dn_if.out_inf, dn_if.out_nan}), 32'h0);
        up_if.in_valid = 1'b0;
        @(negedge clk);

        // -infinity
        drive(1'b1, SIGN_RESULT, EXP_ONES, MSB_ZERO, LSBS_ZEROS, 1'b1, 10'h155, 32'h7FFF_FFFF);
        @(negedge clk);
        check("inf_result", dn_if.out_result, 32'hFF80_0000);
        check("inf_flag",   32'(dn_if.out_inf), 32'h1);
        up_if.in_valid = 1'b0;
        @(negedge clk);

        // quiet NaN
        drive(1'b1, SIGN_ZERO, EXP_ONES, MSB_ONE, LSBS_ZEROS, 1'b1, 10'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        check("nan_result", dn_if.out_result, 32'h7FC0_0000);
        check("nan_flag",   32'(dn_if.out_nan), 32'h1);
        up_if.in_valid = 1'b0;
        @(negedge clk);

        // Backpressure: three words offered, two accepted.
        cnt0 = m_count;
        dn_if.out_ready = 1'b0;
        drive(1'b1, SIGN_RESULT, EXP_RESULT, MSB_RESULT, LSBS_RESULT, 1'b0, 10'd128, 32'h4000_0000);
        @(negedge clk);
        drive(1'b1, SIGN_RESULT, EXP_RESULT, MSB_RESULT, LSBS_RESULT, 1'b0, 10'd129, 32'h4000_0000);
        @(negedge clk);
        drive(1'b1, SIGN_RESULT, EXP_RESULT, MSB_RESULT, LSBS_RESULT, 1'b1, 10'd130, 32'h4000_0000);
        @(negedge clk);
        check("bp_in_ready", 32'(up_if.in_ready), 32'h0);
        check("bp_head",     dn_if.out_result, 32'h4000_0000);
        @(negedge clk);
        check("bp_hold",     dn_if.out_result, 32'h4000_0000);
        check("bp_ready_lo", 32'(up_if.in_ready), 32'h0);
        dn_if.out_ready = 1'b1;
        @(negedge clk);
        check("bp_second", dn_if.out_result, 32'h4080_0000);
        @(negedge clk);
        check("bp_third",  dn_if.out_result, 32'hC100_0000);
        up_if.in_valid = 1'b0;
        @(negedge clk);
        check("bp_count", 32'(dn_if.out_count), 32'(cnt0 + 16'd3));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive_rand(1'($urandom_range(0, 3) != 0));
            dn_if.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end

        // Reset with two words buffered.
        dn_if.out_ready = 1'b0;
        drive_rand(1'b1);
        repeat (3) @(negedge clk);
        up_if.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid",  32'(dn_if.out_valid), 32'h0);
        check("mid_rst_ready",  32'(up_if.in_ready),  32'h0);
        check("mid_rst_result", dn_if.out_result,     32'h0);
        check("mid_rst_count",  32'(dn_if.out_count), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        dn_if.out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(dn_if.out_valid), 32'h0);
        check("post_rst_ready", 32'(up_if.in_ready),  32'h1);

        // Counter wrap: stream until 65535 deliveries.
        drive(1'b1, SIGN_ONE, EXP_RESULT, MSB_RESULT, LSBS_RESULT, 1'b0, 10'd3, 32'h2000_0080);
        guard = 0;
        while (m_count != 16'hFFFF && guard < 70000) begin
            @(negedge clk);
            guard++;
        end
        check("wrap_reached", 32'(guard < 70000), 32'h1);
        check("wrap_ffff", 32'(dn_if.out_count), 32'hFFFF);
        @(negedge clk);
        check("wrap_zero", 32'(dn_if.out_count), 32'h0);
        up_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/result_pack_stage.md
RESULT_PACK_STAGE -- requirements
Module: result_pack_stage

Interface
REQ-001 SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have the port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have the port in_valid, input, 1 bit: upstream word valid.
REQ-004 SHALL have the port in_ready, output, 1 bit: stage can accept a word.
REQ-005 SHALL have the ports sign_select, exponent_select, fraction_msb_select and fraction_lsbs_select, inputs, typed by the sign, exponent, fraction_msb and fraction_lsbs package enums: final selects from result control.
REQ-006 SHALL have the port result_sign, input, 1 bit: computed sign.
REQ-007 SHALL have the port result_exponent, input, 10 bits: biased exponent, signed.
REQ-008 SHALL have the port result_fraction, input, 32 bits: hidden bit at [30], mantissa at [29:7].
REQ-009 SHALL have the port out_valid, output, 1 bit: packed word valid.
REQ-010 SHALL have the port out_ready, input, 1 bit: downstream accepts.
REQ-011 SHALL have the port out_result, output, 32 bits: IEEE-754 single word.
REQ-012 SHALL have the ports out_zero, out_inf and out_nan, outputs, 1 bit each: classification of out_result.
REQ-013 SHALL have the port out_count, output, 16 bits: count of words delivered.

Function
REQ-014 SHALL pack each field per its select:
- sign: RESULT→result_sign, ZERO→0, ONE→1.
- exponent: RESULT→result_exponent[7:0], ZEROS→8'h00, ONES→8'hFF.
- fraction_msb: RESULT→result_fraction[29], ZERO→0, ONE→1.
- fraction_lsbs: RESULT→result_fraction[28:7], ZEROS→22'h0.
REQ-015 SHALL compute the packed word combinationally from inputs and capture it, with its flags, only on an input transfer (in_valid & in_ready).
REQ-016 SHALL derive flags from the packed word:
- out_zero = exponent 0 and mantissa 0.
- out_inf = exponent FF and mantissa 0.
- out_nan = exponent FF and mantissa nonzero.
REQ-017 SHALL buffer words in a 2-entry FIFO (main register plus skid register) so in_ready is a registered signal, never combinationally dependent on out_ready.
REQ-018 SHALL deliver the first word one cycle after capture: latency exactly 1 cycle when the buffer is empty and out_ready=1.
REQ-019 SHALL drive in_ready=1 when occupancy<2 and 0 when occupancy=2.
REQ-020 SHALL on a simultaneous input and output transfer keep occupancy unchanged and deliver words in arrival order.
REQ-021 SHALL move the skid entry into the main register on an output transfer at occupancy 2, so occupancy becomes 1 and in_ready=1 the next cycle.
REQ-022 SHALL hold out_result and the flags stable while out_valid=1 and out_ready=0.
REQ-023 SHALL ignore in_valid while in_ready=0, with no capture and no state change.
REQ-024 SHALL increment out_count on every output transfer (out_valid & out_ready), wrapping from 16'hFFFF to 16'h0000.
REQ-025 SHALL drive out_valid=1 iff occupancy≥1.

Reset
REQ-026 SHALL on reset_n=0 immediately clear occupancy, out_valid, out_zero, out_inf, out_nan, out_result (32'h0) and out_count (16'h0), and drive in_ready=0.
REQ-027 SHALL drive in_ready=1 on the first clock edge after reset_n deasserts.
REQ-028 SHALL on reset mid-operation discard buffered words, with no partial delivery.

Verification
REQ-029 SHALL cover an all-RESULT single word: sign 0, exp 10'd127, fraction 32'h4000_0000 → out_result 32'h3F80_0000 one cycle later, all flags 0.
REQ-030 SHALL cover an infinity select: exponent ONES, fraction_msb ZERO, lsbs ZEROS, sign RESULT=1 → 32'hFF80_0000, out_inf=1.
REQ-031 SHALL cover NaN: exponent ONES, fraction_msb ONE → 32'h7FC0_0000, out_nan=1.
REQ-032 SHALL cover backpressure: out_ready=0 with 3 offered words → 2 accepted, in_ready=0, third held upstream; out_ready=1 → words emerge in order, count +3 after the third is accepted and drained.
REQ-033 SHALL cover counter wrap: out_count preset by 65535 transfers → next transfer reads 0.
REQ-034 SHALL cover a reset pulse with 2 words buffered: out_valid=0 immediately, no stale word after release.
